// File: rtl/karatsuba_mac_pipe_pkg.sv
// Shared width helpers and stage control payload for the Karatsuba MAC pipeline.
package karatsuba_pkg;

  function automatic int half_w(input int w);
    return w / 2;
  endfunction

  function automatic int sum_w(input int w);
    return w / 2 + 1;
  endfunction

  function automatic int pp_w(input int w);
    return w;
  endfunction

  function automatic int p3_w(input int w);
    return w + 2;
  endfunction

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  typedef struct packed {
    logic clr;
  } stage_ctl_t;

endpackage

// File: rtl/karatsuba_mac_pipe_if.sv
// Operand/result stream bundle for karatsuba_mac_pipe.
interface karatsuba_mac_pipe_if #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 2*WIDTH+8
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_clr;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] result;
  logic                 overflow;

  modport master (
    output in_valid, in_clr, a, b, out_ready,
    input  in_ready, out_valid, result, overflow
  );

  modport slave (
    input  in_valid, in_clr, a, b, out_ready,
    output in_ready, out_valid, result, overflow
  );
endinterface

// File: rtl/karatsuba_mac_pipe_mul.sv
// Three-stage Karatsuba multiplier (split/sum, partial products, recombine) with a shared advance enable.
module karatsuba_mul_pipe
  import karatsuba_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      adv,
  input  logic                      in_vld,
  input  logic                      in_clr,
  input  logic [WIDTH-1:0]          a,
  input  logic [WIDTH-1:0]          b,
  output logic                      out_vld,
  output logic                      out_clr,
  output logic [prod_w(WIDTH)-1:0]  prod
);
  localparam int H      = half_w(WIDTH);
  localparam int SW     = sum_w(WIDTH);
  localparam int PPW    = pp_w(WIDTH);
  localparam int P3W    = p3_w(WIDTH);
  localparam int PW     = prod_w(WIDTH);
  localparam int STAGES = 3;

  typedef struct packed {
    stage_ctl_t      ctl;
    logic [H-1:0]    a1, a0, b1, b0;
    logic [SW-1:0]   sa, sb;
  } s1_t;

  typedef struct packed {
    stage_ctl_t      ctl;
    logic [PPW-1:0]  p1, p0;
    logic [P3W-1:0]  p3;
  } s2_t;

  logic [STAGES:1] vld_pipe;
  s1_t             s1, s1_d;
  s2_t             s2, s2_d;
  logic [P3W-1:0]  mid;
  logic [PW-1:0]   prod_d;

  always_comb begin
    s1_d         = '0;
    s1_d.ctl.clr = in_clr;
    s1_d.a1      = a[WIDTH-1:H];
    s1_d.a0      = a[H-1:0];
    s1_d.b1      = b[WIDTH-1:H];
    s1_d.b0      = b[H-1:0];
    s1_d.sa      = SW'(a[WIDTH-1:H]) + SW'(a[H-1:0]);
    s1_d.sb      = SW'(b[WIDTH-1:H]) + SW'(b[H-1:0]);
  end

  always_comb begin
    s2_d     = '0;
    s2_d.ctl = s1.ctl;
    s2_d.p1  = PPW'(s1.a1) * PPW'(s1.b1);
    s2_d.p0  = PPW'(s1.a0) * PPW'(s1.b0);
    s2_d.p3  = P3W'(s1.sa) * P3W'(s1.sb);
  end

  // Cross term a1*b0 + a0*b1 is never negative and needs at most WIDTH+1 bits.
  always_comb begin
    mid    = s2.p3 - P3W'(s2.p1) - P3W'(s2.p0);
    prod_d = {s2.p1, {WIDTH{1'b0}}} + (PW'(mid) << H) + PW'(s2.p0);
  end

  always_ff @(posedge clk) begin
    if (rst)      vld_pipe <= '0;
    else if (adv) vld_pipe <= {vld_pipe[STAGES-1:1], in_vld};
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s1      <= s1_d;
      s2      <= s2_d;
      prod    <= prod_d;
      out_clr <= s2.ctl.clr;
    end
  end

  assign out_vld = vld_pipe[STAGES];
endmodule

// File: rtl/karatsuba_mac_pipe.sv
// Streaming Karatsuba multiply-accumulate: handshake, accumulator and sticky overflow.
// Define KARATSUBA_MAC_SATURATE_EN to clamp the accumulator at all ones instead of wrapping.
module karatsuba_mac_pipe
  import karatsuba_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 2*WIDTH+8
) (
  input logic                 clk,
  input logic                 rst,
  karatsuba_mac_pipe_if.slave bus
);
  localparam int PW = prod_w(WIDTH);

  logic                 adv;
  logic                 m_vld;
  logic                 m_clr;
  logic [PW-1:0]        prod;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH:0]   sum;
  logic                 ovf;
  logic                 out_vld;

  // The whole pipe freezes only while a result waits on the consumer.
  assign adv          = !(out_vld && !bus.out_ready);
  assign bus.in_ready = adv;

  karatsuba_mul_pipe #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .adv     (adv),
    .in_vld  (bus.in_valid),
    .in_clr  (bus.in_clr),
    .a       (bus.a),
    .b       (bus.b),
    .out_vld (m_vld),
    .out_clr (m_clr),
    .prod    (prod)
  );

  assign sum = {1'b0, acc} + (ACC_WIDTH+1)'(prod);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      ovf     <= 1'b0;
      out_vld <= 1'b0;
    end else if (adv) begin
      out_vld <= m_vld;
      if (m_vld) begin
        if (m_clr) begin
          acc <= ACC_WIDTH'(prod);
          ovf <= 1'b0;
        end else begin
          ovf <= ovf | sum[ACC_WIDTH];
`ifdef KARATSUBA_MAC_SATURATE_EN
          acc <= sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
`else
          acc <= sum[ACC_WIDTH-1:0];
`endif
        end
      end
    end
  end

  assign bus.out_valid = out_vld;
  assign bus.result    = acc;
  assign bus.overflow  = ovf;
endmodule

// File: doc/karatsuba_mac_pipe.md
# karatsuba_mac_pipe

Pipelined, parametrised unsigned Karatsuba multiply-accumulate unit. It accepts one operand pair per cycle over a valid/ready handshake and splits each operand into halves. It forms the three Karatsuba partial products in a registered pipeline and accumulates the exact 2·WIDTH-bit product into a wide accumulator. It sits in the accelerator datapath as the streaming successor of the combinational single-shot Karatsuba multiplier.

## Interface
- WIDTH, 32: operand width in bits; must be even and ≥ 4.
- ACC_WIDTH, 2*WIDTH+8: accumulator width; must be ≥ 2*WIDTH.
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  unit can accept this cycle.
- in_clr  input  1  sampled with the operand pair: load accumulator with this product instead of adding.
- a  input  WIDTH  unsigned operand A.
- b  input  WIDTH  unsigned operand B.
- out_valid  output  1  result holds a new accumulator value.
- out_ready  input  1  consumer takes result this cycle.
- result  output  ACC_WIDTH  accumulator value after the corresponding sample.
- overflow  output  1  sticky: accumulation exceeded ACC_WIDTH since last clear.

## Operation
- H = WIDTH/2. a1 = a[WIDTH-1:H], a0 = a[H-1:0], and likewise b1 and b0.
- S1 registers a1, a0, b1, b0, sa = a1+a0, sb = b1+b0 (H+1 bits each), and clr.
- S2 registers p1 = a1·b1 and p0 = a0·b0 (WIDTH bits each), and p3 = sa·sb (WIDTH+2 bits).
- S3 computes prod = (p1<<WIDTH) + ((p3−p1−p0)<<H) + p0, exact in 2·WIDTH bits. The middle term is non-negative and fits in WIDTH+1 bits.
- S3 then updates the accumulator:
  - If clr: acc = prod (zero-extended) and overflow is cleared.
  - Otherwise: acc = acc + prod. The sum wraps modulo 2^ACC_WIDTH. A carry out of bit ACC_WIDTH−1 sets overflow.
- result always equals the accumulator register. out_valid marks a fresh update.
- Each pipeline stage carries its own valid bit. Bubbles propagate without touching the accumulator.
- Samples complete strictly in acceptance order. No sample is ever dropped or duplicated.

## Timing
- Reset: all stage valids = 0, out_valid = 0, result = 0, overflow = 0, in_ready = 1.
- Reset mid-operation discards in-flight samples. No output for them is ever produced.
- advance = !(out_valid && !out_ready). in_ready = advance, with no dependency on in_valid.
- A sample is accepted on an edge where in_valid && in_ready. All stages shift only when advance = 1.
- Latency: a sample accepted at edge n produces out_valid = 1 after edge n+3, when unstalled.
- Throughput is one sample per cycle.
- While stalled (advance = 0), every stage, the accumulator, result, out_valid and overflow hold their values.
- Result hand-off: out_valid && out_ready on an edge with no new S3 sample leaves out_valid = 0 after that edge.
- Simultaneous consume and new S3 sample: out_valid stays 1 and result updates.
- in_clr on the first sample after reset is optional, because the accumulator is already 0.

## Configuration
- KARATSUBA_MAC_SATURATE_EN defined:
  - A non-clr accumulation whose sum exceeds 2^ACC_WIDTH−1 sets acc to all ones.
  - overflow is set.
  - Further additions keep acc at all ones until the next clr.
- KARATSUBA_MAC_SATURATE_EN undefined: modulo wrap as described under Operation. overflow is still sticky.

## Structure
- Package karatsuba_pkg holds:
  - Localparam helpers for derived widths: half width, partial-product widths, product width.
  - A stage payload struct typedef for S1 and S2 registers.
- Sub-module karatsuba_mul_pipe: stages S1–S3 producing prod and a valid bit, with a shared advance enable.
- The top level holds the handshake, accumulator, overflow and saturation logic.

## Test plan
- Reset then idle, WIDTH=32 → out_valid=0, result=0, overflow=0, in_ready=1 for 10 cycles.
- a=12345678, b=87654321, in_clr=1 → three edges later out_valid=1, result=1082152022374638.
- a=b=0xFFFFFFFF, in_clr=1 → result=0xFFFFFFFE00000001, overflow=0.
- Back-to-back samples (clr,2,3), (0,4,5), (0,7,0) → results 6, 26, 26 on consecutive cycles.
- Stream 5 samples with out_ready held low 4 cycles:
  - in_ready=0 while out_valid && !out_ready.
  - All 5 results appear in order with correct running sums.
  - result is stable while stalled.
- ACC_WIDTH=64, samples (clr,0xFFFFFFFF,0xFFFFFFFF) then the same pair without clr:
  - Without the macro: result=0xFFFFFFFC00000002, overflow=1.
  - With KARATSUBA_MAC_SATURATE_EN: result=0xFFFFFFFFFFFFFFFF, overflow=1.
  - A subsequent clr sample clears overflow.
